// File: rtl/class_arbiter.sv
// ---------------------------------------------------------------------------
// class_arbiter
//
// Egress merge of the two per-class FIFOs (class 0 / class 1) into a single
// stream. Weighted round-robin: the preferred class keeps the grant for up to
// WEIGHTk consecutive pops while the other class is eligible, and for as long
// as it likes while the other class is not. Downstream backpressure (out_full)
// stops new pops only; words already popped still drain.
//
// Timing: pop in cycle N -> FIFO data in cycle N+1 -> out/valid_out/grant
// registered at the N+1 -> N+2 edge (pop-to-valid latency of 2 cycles, one
// word per cycle sustained).
//
// Optional feature macro: CLASS_ARB_CHECK_EN
//   defined   : sticky Error flag set when a forwarded word's class bit
//               (bit DATA_SIZE-1) disagrees with the FIFO it was read from.
//   undefined : Error is tied low and no compare logic exists.
//
// Ports:
//   clk          in   single clock, all state on posedge
//   reset        in   asynchronous active-low reset
//   data0/data1  in   class FIFO read data, valid the cycle after pop_0/pop_1
//   fifo_empty0/1 in  class FIFO empty flags
//   out_full     in   downstream almost-full, blocks new pops
//   pop_0/pop_1  out  class FIFO read strobes (combinational)
//   out          out  merged data word (registered)
//   valid_out    out  out carries a new word this cycle (registered)
//   grant        out  class of the word on out (registered)
//   Error        out  sticky class-mismatch flag
// ---------------------------------------------------------------------------
module class_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int WEIGHT0   = 3,
  parameter int WEIGHT1   = 1,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] data0,
  input  logic [DATA_SIZE-1:0] data1,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 out_full,
  output logic                 pop_0,
  output logic                 pop_1,
  output logic [DATA_SIZE-1:0] out,
  output logic                 valid_out,
  output logic                 grant,
  output logic                 Error
);

  typedef enum logic [0:0] {
    SERVE0 = 1'b0,
    SERVE1 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] W0_C  = CNT_W'(WEIGHT0);
  localparam logic [CNT_W-1:0] W1_C  = CNT_W'(WEIGHT1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  // FSM and burst counter
  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;

  // Eligibility seen from the currently preferred class
  logic             elig0_s;
  logic             elig1_s;
  logic             cur_elig_s;
  logic             oth_elig_s;
  logic [CNT_W-1:0] cur_w_s;
  logic             take_cur_s;
  logic             take_oth_s;

  // Pop strobes
  logic             pop0_s;
  logic             pop1_s;

  // Pipeline: pop stage and output stage
  logic                 sel_r;
  logic                 v_r;
  logic [DATA_SIZE-1:0] data_sel_s;
  logic [DATA_SIZE-1:0] out_r;
  logic                 valid_r;
  logic                 grant_r;

  // Eligibility and the current/other view of the two classes
  always_comb begin
    elig0_s    = ~fifo_empty0 & ~out_full;
    elig1_s    = ~fifo_empty1 & ~out_full;
    cur_elig_s = 1'b0;
    oth_elig_s = 1'b0;
    cur_w_s    = W0_C;
    case (state_r)
      SERVE0: begin
        cur_elig_s = elig0_s;
        oth_elig_s = elig1_s;
        cur_w_s    = W0_C;
      end
      SERVE1: begin
        cur_elig_s = elig1_s;
        oth_elig_s = elig0_s;
        cur_w_s    = W1_C;
      end
      default: begin
        cur_elig_s = 1'b0;
        oth_elig_s = 1'b0;
        cur_w_s    = W0_C;
      end
    endcase
  end

  // WRR decision: keep the current class until its burst budget is spent,
  // unless the other class has nothing to offer; otherwise hand over.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    take_cur_s = 1'b0;
    take_oth_s = 1'b0;
    if (cur_elig_s && ((cnt_r < cur_w_s) || !oth_elig_s)) begin
      take_cur_s = 1'b1;
      // Saturate at the weight so a long solo run can never wrap the counter.
      if (cnt_r < cur_w_s) begin
        cnt_nx_s = cnt_r + ONE_C;
      end else begin
        cnt_nx_s = cnt_r;
      end
    end else if (oth_elig_s) begin
      take_oth_s = 1'b1;
      state_nx_s = (state_r == SERVE0) ? SERVE1 : SERVE0;
      cnt_nx_s   = ONE_C;
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
  end

  // Map the current/other decision onto the physical FIFO strobes
  always_comb begin
    pop0_s = 1'b0;
    pop1_s = 1'b0;
    if (reset) begin
      case (state_r)
        SERVE0: begin
          pop0_s = take_cur_s;
          pop1_s = take_oth_s;
        end
        SERVE1: begin
          pop1_s = take_cur_s;
          pop0_s = take_oth_s;
        end
        default: begin
          pop0_s = 1'b0;
          pop1_s = 1'b0;
        end
      endcase
    end else begin
      // Strobes must be quiet while reset is held, independent of FSM state.
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end
  end

  assign pop_0 = pop0_s;
  assign pop_1 = pop1_s;

  // FSM state and burst counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= SERVE0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Pop stage: remember which FIFO was read so its data can be picked next cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_r   <= 1'b0;
      sel_r <= 1'b0;
    end else begin
      v_r <= pop0_s | pop1_s;
      if (pop0_s || pop1_s) begin
        sel_r <= pop1_s;
      end else begin
        sel_r <= sel_r;
      end
    end
  end

  // Select the FIFO whose read data is arriving this cycle
  always_comb begin
    data_sel_s = data0;
    case (sel_r)
      1'b0:    data_sel_s = data0;
      1'b1:    data_sel_s = data1;
      default: data_sel_s = data0;
    endcase
  end

  // Output stage: capture the word on valid, hold out/grant otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_r   <= '0;
      grant_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= v_r;
      if (v_r) begin
        out_r   <= data_sel_s;
        grant_r <= sel_r;
      end else begin
        out_r   <= out_r;
        grant_r <= grant_r;
      end
    end
  end

  assign out       = out_r;
  assign valid_out = valid_r;
  assign grant     = grant_r;

`ifdef CLASS_ARB_CHECK_EN
  // True when a word's embedded class bit disagrees with its source FIFO
  function automatic logic class_mismatch(input logic [DATA_SIZE-1:0] word,
                                          input logic                 cls);
    return word[DATA_SIZE-1] != cls;
  endfunction

  logic error_r;

  // Sticky mismatch flag; the offending word is still forwarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_r <= 1'b0;
    end else if (v_r && class_mismatch(data_sel_s, sel_r)) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign Error = error_r;
`else
  assign Error = 1'b0;
`endif

endmodule

// File: tb/tb_class_arbiter.sv
// ---------------------------------------------------------------------------
// tb_class_arbiter
//
// Self-checking bench for class_arbiter (WEIGHT0=3, WEIGHT1=1). The two class
// FIFOs are modelled as queues; a behavioural WRR model decides every cycle
// which class should be popped and predicts out/valid_out/grant/Error two
// cycles later. Directed phases (reset, WRR order, single class, both empty,
// backpressure, class mismatch) are followed by a randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_class_arbiter;

  localparam int DW = 10;

`ifdef CLASS_ARB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          fifo_empty0;
  logic          fifo_empty1;
  logic          out_full;
  logic          pop_0;
  logic          pop_1;
  logic [DW-1:0] out;
  logic          valid_out;
  logic          grant;
  logic          Error;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  class_arbiter #(
    .DATA_SIZE(DW),
    .WEIGHT0  (3),
    .WEIGHT1  (1),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data0      (data0),
    .data1      (data1),
    .fifo_empty0(fifo_empty0),
    .fifo_empty1(fifo_empty1),
    .out_full   (out_full),
    .pop_0      (pop_0),
    .pop_1      (pop_1),
    .out        (out),
    .valid_out  (valid_out),
    .grant      (grant),
    .Error      (Error)
  );

  int n_err    = 0;
  int n_checks = 0;

  // FIFO contents
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Reference model: preferred class, length of its current grant run,
  // two-deep delay line of granted words, and the predicted output registers.
  int            pref = 0;
  int            run  = 0;
  bit            d1_v = 1'b0;
  bit            d2_v = 1'b0;
  logic [DW-1:0] d1_w = '0;
  logic [DW-1:0] d2_w = '0;
  int            d1_c = 0;
  int            d2_c = 0;
  logic [DW-1:0] exp_out = '0;
  int            exp_grant = 0;
  bit            exp_err = 1'b0;

  // Observation log for the directed sequence checks
  logic [DW-1:0] obs_w[$];
  int            obs_g[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            pops0_seen = 0;
  int            pops_seen = 0;

  logic [DW-1:0] wrr_w[7] = '{10'h0FF, 10'h0EE, 10'h1BB, 10'h2DD, 10'h0AA, 10'h2CC, 10'h299};
  int            wrr_g[7] = '{0, 0, 0, 1, 0, 1, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered at posedge+1, samples at the negedge, returns at
  // the next posedge+1 with the FIFO read data for this cycle's pop applied.
  task automatic step();
    bit            e0, e1, ec, eo;
    int            cur, oth, lim, choice;
    logic [DW-1:0] w;
    fifo_empty0 = (q0.size() == 0);
    fifo_empty1 = (q1.size() == 0);
    #4;
    e0  = (q0.size() != 0) && !out_full;
    e1  = (q1.size() != 0) && !out_full;
    cur = pref;
    oth = 1 - pref;
    ec  = (cur == 0) ? e0 : e1;
    eo  = (cur == 0) ? e1 : e0;
    lim = (cur == 0) ? 3 : 1;
    choice = -1;
    if (ec && (run < lim || !eo)) begin
      choice = cur;
      if (run < lim) run++;
    end else if (eo) begin
      choice = oth;
      pref   = oth;
      run    = 1;
    end
    check("pop_0", 32'(pop_0), 32'(choice == 0));
    check("pop_1", 32'(pop_1), 32'(choice == 1));
    if (d2_v) begin
      exp_out   = d2_w;
      exp_grant = d2_c;
      if (CHK && (d2_w[DW-1] != d2_c[0])) exp_err = 1'b1;
    end
    check("valid_out", 32'(valid_out), 32'(d2_v));
    check("out", 32'(out), 32'(exp_out));
    check("grant", 32'(grant), 32'(exp_grant));
    check("Error", 32'(Error), 32'(exp_err));
    if (valid_out === 1'b1) begin
      obs_w.push_back(out);
      obs_g.push_back(int'(grant));
      obs_cyc.push_back(cyc);
    end
    if (pop_0 === 1'b1) pops0_seen++;
    if ((pop_0 === 1'b1) || (pop_1 === 1'b1)) pops_seen++;
    d2_v = d1_v;
    d2_w = d1_w;
    d2_c = d1_c;
    d1_v = (choice >= 0);
    d1_c = (choice >= 0) ? choice : 0;
    d1_w = (choice == 0) ? q0[0] : ((choice == 1) ? q1[0] : '0);
    @(posedge clk);
    #1;
    // Unread FIFO outputs carry junk so a stray capture is visible.
    data0 = DW'($urandom);
    data1 = DW'($urandom);
    if (choice == 0) begin
      w = q0.pop_front();
      data0 = w;
    end else if (choice == 1) begin
      w = q1.pop_front();
      data1 = w;
    end
    cyc++;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Directed phases followed by randomized traffic
  initial begin
    int            bp_start, win_start;
    logic [DW-1:0] c0[$];
    logic [DW-1:0] c1[$];
    logic [DW-1:0] e0q[$];
    logic [DW-1:0] e1q[$];
    bit            seen;

    // ---- Reset with both FIFOs loaded (WRR scenario contents) ----
    reset    = 1'b0;
    out_full = 1'b0;
    data0    = '0;
    data1    = '0;
    q0 = '{10'h0FF, 10'h0EE, 10'h1BB, 10'h0AA};
    q1 = '{10'h2DD, 10'h2CC, 10'h299};
    fifo_empty0 = 1'b0;
    fifo_empty1 = 1'b0;
    #12;
    check("rst_pop_0", 32'(pop_0), 32'd0);
    check("rst_pop_1", 32'(pop_1), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_Error", 32'(Error), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ---- WRR order: first pop right after release, then 3:1 interleave ----
    obs_w.delete(); obs_g.delete(); obs_cyc.delete();
    run_steps(10);
    check("wrr_count", 32'(obs_w.size()), 32'd7);
    for (int i = 0; i < 7 && i < obs_w.size(); i++) begin
      check($sformatf("wrr_word%0d", i), 32'(obs_w[i]), 32'(wrr_w[i]));
      check($sformatf("wrr_grant%0d", i), 32'(obs_g[i]), 32'(wrr_g[i]));
    end
    if (obs_cyc.size() == 7) check("wrr_no_bubble", 32'(obs_cyc[6] - obs_cyc[0]), 32'd6);
    if (obs_cyc.size() != 0) check("wrr_first_latency", 32'(obs_cyc[0]), 32'd2);

    // ---- Single class: only FIFO1 has data ----
    obs_w.delete(); obs_g.delete(); obs_cyc.delete();
    pops0_seen = 0;
    q1 = '{10'h277, 10'h2CC};
    run_steps(6);
    check("single_count", 32'(obs_w.size()), 32'd2);
    if (obs_w.size() == 2) begin
      check("single_word0", 32'(obs_w[0]), 32'h277);
      check("single_word1", 32'(obs_w[1]), 32'h2CC);
    end
    check("single_no_pop0", 32'(pops0_seen), 32'd0);

    // ---- Both empty: nothing popped, out holds last word ----
    pops_seen = 0;
    run_steps(4);
    check("empty_pops", 32'(pops_seen), 32'd0);
    check("empty_out_hold", 32'(out), 32'h2CC);
    check("empty_valid", 32'(valid_out), 32'd0);

    // ---- Backpressure window of 5 cycles mid-stream ----
    e0q = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014, 10'h015};
    e1q = '{10'h210, 10'h211, 10'h212, 10'h213};
    q0 = e0q;
    q1 = e1q;
    bp_start = obs_w.size();
    run_steps(3);
    out_full  = 1'b1;
    pops_seen = 0;
    win_start = obs_w.size();
    run_steps(5);
    check("bp_window_pops", 32'(pops_seen), 32'd0);
    check("bp_inflight_words", 32'(obs_w.size() - win_start), 32'd2);
    out_full = 1'b0;
    run_steps(15);
    check("bp_total_words", 32'(obs_w.size() - bp_start), 32'd10);
    for (int i = bp_start; i < obs_w.size(); i++) begin
      if (obs_g[i] == 0) c0.push_back(obs_w[i]);
      else c1.push_back(obs_w[i]);
    end
    check("bp_class0_count", 32'(c0.size()), 32'd6);
    check("bp_class1_count", 32'(c1.size()), 32'd4);
    for (int i = 0; i < c0.size() && i < 6; i++)
      check($sformatf("bp_class0_word%0d", i), 32'(c0[i]), 32'(e0q[i]));
    for (int i = 0; i < c1.size() && i < 4; i++)
      check($sformatf("bp_class1_word%0d", i), 32'(c1[i]), 32'(e1q[i]));

    // ---- Randomized traffic with random backpressure ----
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 8 && $urandom_range(0, 2) == 0)
        q0.push_back({1'b0, 9'($urandom)});
      if (q1.size() < 8 && $urandom_range(0, 2) == 0)
        q1.push_back({1'b1, 9'($urandom)});
      out_full = ($urandom_range(0, 3) == 0);
      step();
    end
    out_full = 1'b0;
    run_steps(30);
    check("rand_drained0", 32'(q0.size()), 32'd0);
    check("rand_drained1", 32'(q1.size()), 32'd0);

    // ---- Class-1 tagged word delivered through FIFO0 ----
    obs_w.delete(); obs_g.delete(); obs_cyc.delete();
    q0 = '{10'h2A7};
    run_steps(4);
    seen = 1'b0;
    for (int i = 0; i < obs_w.size(); i++)
      if (obs_w[i] == 10'h2A7 && obs_g[i] == 0) seen = 1'b1;
    check("mismatch_forwarded", 32'(seen), 32'd1);
    check("mismatch_Error", 32'(Error), 32'(CHK));
    run_steps(3);
    check("mismatch_Error_sticky", 32'(Error), 32'(CHK));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
